// File: rtl/gshare_branch_predictor_pkg.sv
// Shared constants, counter encodings and the FE-latch prediction record
// for the gshare branch predictor.
package gshare_branch_predictor_pkg;

    localparam int DBITS_D        = 32;
    localparam int BHR_BITS_D     = 8;
    localparam int BTB_IDX_BITS_D = 4;

    // 2-bit saturating counter states
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam logic [1:0] PHT_INIT_D = 2'(WNT);

    // Field order of the prediction as it travels through the FE latch
    typedef struct packed {
        logic                  taken;
        logic [BHR_BITS_D-1:0] bhr;
        logic [BHR_BITS_D-1:0] pht_index;
        logic [1:0]            pht_entry;
    } fe_pred_t;

    // Saturating step of a 2-bit counter toward the resolved outcome
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'(ST)) nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'(SNT)) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_btb_table.sv
// Direct-mapped branch target buffer: valid/tag/target per entry,
// combinational read with hit, synchronous write, synchronous clear of valids.
module gshare_branch_predictor_btb_table
    import gshare_branch_predictor_pkg::*;
#(
    parameter int DBITS    = DBITS_D,
    parameter int IDX_BITS = BTB_IDX_BITS_D
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [DBITS-1:0] rd_pc,
    output logic             rd_hit,
    output logic [DBITS-1:0] rd_target,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wr_pc,
    input  logic [DBITS-1:0] wr_target
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = DBITS - IDX_BITS - 2;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [DBITS-1:0] tgt_q   [ENTRIES];

    logic [IDX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]    rd_tag, wr_tag;

    // PCs are word aligned, so the byte-offset bits carry no information
    logic unused_bits;
    assign unused_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    assign rd_idx = rd_pc[IDX_BITS+1:2];
    assign rd_tag = rd_pc[DBITS-1:IDX_BITS+2];
    assign wr_idx = wr_pc[IDX_BITS+1:2];
    assign wr_tag = wr_pc[DBITS-1:IDX_BITS+2];

    // Read reflects pre-write contents; a write lands on the next edge
    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_target = tgt_q[rd_idx];

    // Valid bits: cleared on reset, set by a write (overwrites any alias)
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/target payload needs no reset; it is masked by the valid bit
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor: global history XOR PC indexes a table of 2-bit counters,
// a direct-mapped BTB supplies the target. Lookup is combinational; resolved
// branches from AGEX train history, counters and BTB on the clock edge.
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int         DBITS        = DBITS_D,
    parameter int         BHR_BITS     = BHR_BITS_D,
    parameter int         BTB_IDX_BITS = BTB_IDX_BITS_D,
    parameter logic [1:0] PHT_INIT     = PHT_INIT_D
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DBITS-1:0]    lookup_pc,
    output logic                pred_taken,
    output logic [DBITS-1:0]    pred_target,
    output logic [BHR_BITS-1:0] pred_bhr,
    output logic [BHR_BITS-1:0] pred_pht_index,
    output logic [1:0]          pred_pht_entry,
    input  logic                upd_valid,
    input  logic [DBITS-1:0]    upd_pc,
    input  logic                upd_taken,
    input  logic [DBITS-1:0]    upd_target,
    input  logic [BHR_BITS-1:0] upd_pht_index,
    input  logic                upd_pred_taken,
    output logic [31:0]         num_branches,
    output logic [31:0]         num_mispredicts
);

    localparam int PHT_ENTRIES = 1 << BHR_BITS;

    logic [BHR_BITS-1:0] bhr_q, bhr_d;
    logic [1:0]          pht_q [PHT_ENTRIES];
    logic [31:0]         nbr_q, nbr_d;
    logic [31:0]         nmis_q, nmis_d;

    logic                btb_hit;
    logic [DBITS-1:0]    btb_target;

    gshare_branch_predictor_btb_table #(
        .DBITS    (DBITS),
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk       (clk),
        .clr_n     (reset),
        .rd_pc     (lookup_pc),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (reset && upd_valid && upd_taken),
        .wr_pc     (upd_pc),
        .wr_target (upd_target)
    );

    // Lookup: everything below is a pure function of lookup_pc and current state
    assign pred_bhr       = bhr_q;
    assign pred_pht_index = lookup_pc[BHR_BITS+1:2] ^ bhr_q;
    assign pred_pht_entry = pht_q[pred_pht_index];
    assign pred_taken     = btb_hit && pred_pht_entry[1];
    assign pred_target    = pred_taken ? btb_target : lookup_pc + DBITS'(4);

    assign num_branches    = nbr_q;
    assign num_mispredicts = nmis_q;

    // Next history and performance counters for a resolved branch
    always_comb begin
        bhr_d  = bhr_q;
        nbr_d  = nbr_q;
        nmis_d = nmis_q;
        if (upd_valid) begin
            bhr_d = {bhr_q[BHR_BITS-2:0], upd_taken};
            nbr_d = nbr_q + 32'd1;
            if (upd_pred_taken != upd_taken) nmis_d = nmis_q + 32'd1;
        end
    end

    // History and counter registers; an update during reset is dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            bhr_q  <= '0;
            nbr_q  <= '0;
            nmis_q <= '0;
        end else begin
            bhr_q  <= bhr_d;
            nbr_q  <= nbr_d;
            nmis_q <= nmis_d;
        end
    end

    // PHT read-modify-write uses the live table entry, not the carried one
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= PHT_INIT;
        end else if (upd_valid) begin
            pht_q[upd_pht_index] <= ctr_next(pht_q[upd_pht_index], upd_taken);
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected
// lookup response; a monitor pops and compares after the outputs settle.
module tb_gshare_branch_predictor;
    import gshare_branch_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_bhr;
    logic [7:0]  pred_pht_index;
    logic [1:0]  pred_pht_entry;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_pht_index;
    logic        upd_pred_taken;
    logic [31:0] num_branches;
    logic [31:0] num_mispredicts;

    gshare_branch_predictor dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_pc       (lookup_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .pred_bhr        (pred_bhr),
        .pred_pht_index  (pred_pht_index),
        .pred_pht_entry  (pred_pht_entry),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pht_index   (upd_pht_index),
        .upd_pred_taken  (upd_pred_taken),
        .num_branches    (num_branches),
        .num_mispredicts (num_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        fe_pred_t    fe;
        logic [31:0] target;
        logic [31:0] nbr;
        logic [31:0] nmis;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: plain integer tables, BTB keyed by stored full PC
    int unsigned m_pht [256];
    int unsigned m_bhr;
    bit          m_bv  [16];
    int unsigned m_bpc [16];
    int unsigned m_btgt[16];
    int unsigned m_nbr, m_nmis;

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) m_bv[i] = 0;
        m_bhr = 0; m_nbr = 0; m_nmis = 0;
    endfunction

    function automatic exp_t predict(input logic [31:0] pc);
        exp_t        e;
        int unsigned idx, bi;
        bit          hit;
        idx = ((pc / 4) % 256) ^ m_bhr;
        bi  = (pc / 4) % 16;
        hit = m_bv[bi] && ((m_bpc[bi] / 64) == (pc / 64));
        e.fe.bhr       = 8'(m_bhr);
        e.fe.pht_index = 8'(idx);
        e.fe.pht_entry = 2'(m_pht[idx]);
        e.fe.taken     = hit && (m_pht[idx] >= 2);
        e.target       = e.fe.taken ? m_btgt[bi] : pc + 4;
        e.nbr          = m_nbr;
        e.nmis         = m_nmis;
        return e;
    endfunction

    function automatic void model_update(input logic [31:0] upc, input bit t,
                                         input logic [31:0] tgt, input logic [7:0] ui,
                                         input bit pt);
        int unsigned bi;
        if (t) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
        else   m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
        m_bhr = ((m_bhr * 2) + (t ? 1 : 0)) % 256;
        if (t) begin
            bi = (upc / 4) % 16;
            m_bv[bi] = 1; m_bpc[bi] = upc; m_btgt[bi] = tgt;
        end
        m_nbr  = m_nbr + 1;
        if (pt != t) m_nmis = m_nmis + 1;
    endfunction

    // Lookup PC whose gshare index equals i under the current model history
    function automatic logic [31:0] pc_for_index(input int unsigned i);
        return 32'(((i ^ m_bhr) % 256) * 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: compare the settled combinational response each cycle
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pred_taken",      {31'd0, pred_taken},     {31'd0, e.fe.taken});
            chk("pred_target",     pred_target,             e.target);
            chk("pred_bhr",        {24'd0, pred_bhr},       {24'd0, e.fe.bhr});
            chk("pred_pht_index",  {24'd0, pred_pht_index}, {24'd0, e.fe.pht_index});
            chk("pred_pht_entry",  {30'd0, pred_pht_entry}, {30'd0, e.fe.pht_entry});
            chk("num_branches",    num_branches,            e.nbr);
            chk("num_mispredicts", num_mispredicts,         e.nmis);
        end
    end

    // One cycle: drive inputs, queue the expected response, then advance model
    task automatic step(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                        input bit ut, input logic [31:0] utgt, input logic [7:0] ui,
                        input bit upt, input bit rst_n);
        @(negedge clk);
        lookup_pc = pc; reset = rst_n;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_pht_index = ui; upd_pred_taken = upt;
        exp_q.push_back(predict(pc));
        if (!rst_n) model_reset();
        else if (uv) model_update(upc, ut, utgt, ui, upt);
    endtask

    task automatic look(input logic [31:0] pc);
        step(pc, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input logic [7:0] ui, input bit upt);
        step(pc, 1, upc, ut, utgt, ui, upt, 1);
    endtask

    initial begin
        logic [31:0] pc, upc;
        logic [7:0]  ui;
        exp_t        tmp;
        reset = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pht_index = '0; upd_pred_taken = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state: 0x100 -> not taken, +4, index 0x40, weakly not-taken
        look(32'h100);

        // Two taken updates at 0x40 with concurrent lookup of same PC
        upd(32'h100, 32'h100, 1, 32'h80, 8'h40, 0);
        upd(32'h100, 32'h100, 1, 32'h80, 8'h40, 0);
        look(32'h100);                                   // index 0x43, entry 1
        // Drive PHT[0x43] to ST, then rebuild history to 0x03
        upd(32'h0, 32'h100, 1, 32'h80, 8'h43, 0);
        upd(32'h0, 32'h100, 1, 32'h80, 8'h43, 0);
        for (int i = 0; i < 6; i++) upd(32'h0, 32'h200, 0, 32'h0, 8'h01, 0);
        upd(32'h0, 32'h100, 1, 32'h80, 8'h43, 1);
        upd(32'h0, 32'h100, 1, 32'h80, 8'h43, 1);
        look(32'h100);                                   // taken, target 0x80

        // Saturation at index 0x10, observing the entry through the lookup
        for (int i = 0; i < 5; i++) upd(pc_for_index(8'h10), 32'h300, 1, 32'h40, 8'h10, 1);
        look(pc_for_index(8'h10));
        for (int i = 0; i < 5; i++) upd(pc_for_index(8'h10), 32'h300, 0, 32'h40, 8'h10, 0);
        look(pc_for_index(8'h10));

        // BTB alias: 0x500 evicts 0x100
        upd(32'h0, 32'h100, 1, 32'h80, 8'h20, 0);
        upd(32'h0, 32'h500, 1, 32'h900, 8'h21, 0);
        look(32'h100);
        look(32'h500);

        // Same-cycle update and lookup of one counter: old now, new next cycle
        upd(pc_for_index(8'h55), 32'h0, 1, 32'h0, 8'h55, 0);
        look(pc_for_index(8'h55));

        // Reset mid-stream with an update pending
        step(32'h100, 1, 32'h100, 1, 32'h80, 8'h40, 0, 0);
        look(32'h100);
        look(32'h500);

        // Random traffic with occasional reset and frequent index collisions
        for (int n = 0; n < 400; n++) begin
            pc  = 32'($urandom_range(0, 255)) * 4;
            upc = 32'($urandom_range(0, 255)) * 4;
            tmp = predict(pc);
            ui  = ($urandom_range(0, 1) == 1) ? tmp.fe.pht_index : 8'($urandom_range(0, 255));
            step(pc, $urandom_range(0, 3) != 0, upc, $urandom_range(0, 1) == 1,
                 32'($urandom) & 32'hFFFF_FFFC, ui, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 49) != 0);
        end

        // Every queued expectation must have been consumed by the monitor
        @(negedge clk);
        #3;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Fetch-side producer of the branch-prediction fields that travel through the FE latch: taken, BHR, PHT_index and PHT_entry.
- Combines a gshare PHT with a direct-mapped BTB.
- FE queries it combinationally with the fetch PC.
- Resolved-branch updates arrive from AGEX and are written on the clock edge.
- Mispredict counters are exported for performance readout.

Parameters:
DBITS, 32, data/PC width
BHR_BITS, 8, global history length; PHT has 2^BHR_BITS entries
BTB_IDX_BITS, 4, log2 of BTB entries (16)
PHT_INIT, 2'b01, reset value of every PHT counter (weakly not-taken)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-low reset (0 = reset)
lookup_pc  in  DBITS  fetch PC
pred_taken  out  1  predicted taken (BTB hit and PHT counter[1])
pred_target  out  DBITS  BTB target; lookup_pc+4 when pred_taken=0
pred_bhr  out  BHR_BITS  BHR value used for this lookup
pred_pht_index  out  BHR_BITS  lookup_pc[BHR_BITS+1:2] XOR BHR
pred_pht_entry  out  2  PHT counter read at pred_pht_index
upd_valid  in  1  AGEX resolved a conditional branch this cycle
upd_pc  in  DBITS  PC of resolved branch
upd_taken  in  1  actual outcome
upd_target  in  DBITS  actual taken target
upd_pht_index  in  BHR_BITS  index carried down the pipe from lookup
upd_pred_taken  in  1  prediction carried down the pipe
num_branches  out  32  count of updates
num_mispredicts  out  32  count of updates with upd_pred_taken != upd_taken

Behaviour:
- Lookup path is purely combinational, with zero latency.
  - BTB index = lookup_pc[BTB_IDX_BITS+1:2]; tag = lookup_pc[DBITS-1:BTB_IDX_BITS+2].
  - Hit = entry valid and tag equal.
  - pred_taken = hit && pht[pred_pht_index][1].
- State (BHR, PHT, BTB valid/tag/target, counters) changes only on the rising clk edge.
- Reset (reset==0 at the edge):
  - BHR <= 0.
  - Every PHT entry <= PHT_INIT.
  - Every BTB valid <= 0.
  - num_branches and num_mispredicts <= 0.
  - An update presented in a reset cycle is discarded.
  - Reset outputs after the reset edge, with lookup_pc=P: pred_taken=0, pred_target=P+4, pred_bhr=0, pred_pht_entry=2'b01.
- Update, when upd_valid=1 and not reset:
  - PHT[upd_pht_index] does a 2-bit saturating increment if upd_taken, else a decrement; it saturates at 3 and at 0.
  - The read-modify-write uses the current table content, not any carried entry.
  - BHR <= {BHR[BHR_BITS-2:0], upd_taken} (non-speculative history).
  - If upd_taken: the BTB entry at upd_pc's index gets valid=1, tag=upd_pc tag, target=upd_target, overwriting any alias.
  - If not taken, the BTB is unchanged.
  - num_branches += 1. num_mispredicts += 1 if upd_pred_taken != upd_taken. Both wrap modulo 2^32.
- Simultaneous lookup and update touching the same PHT/BTB entry: the lookup returns the pre-update value; the new value is visible from the next cycle.
- upd_valid=0: no state change.
- The block has no internal stall. FE holds lookup_pc stable while stalled, so outputs stay stable.

Decomposition:
- define.vh gets these constants:
  - BHR_BITS and BTB_IDX_BITS widths.
  - The counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - The FE-latch field order {taken, BHR, PHT_index, PHT_entry}.
- One natural sub-module, btb_table:
  - Direct-mapped valid/tag/target array.
  - Combinational read with hit output; synchronous write; synchronous active-low clear of valid bits.
- PHT and BHR stay in the top module.

Test Plan:
- Reset, then lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, pred_bhr=0x00, pred_pht_index=0x40, pred_pht_entry=1.
- Two updates, pc=0x100, taken=1, target=0x80, index=0x40, pred_taken=0 -> PHT[0x40] goes 1->2->3.
  - BHR goes 0x00->0x01->0x03.
  - num_mispredicts=2.
  - A lookup of 0x100 with BHR=0x03 (index 0x43) shows pred_pht_entry=1, pred_taken=0.
  - After a forced PHT[0x43]=ST via updates, the lookup gives pred_taken=1, pred_target=0x80.
- Saturation:
  - Five taken updates at index 0x10 -> counter holds 3.
  - Five not-taken updates -> counter holds 0, never wrapping.
- BTB alias:
  - Taken update pc=0x100, then taken update pc=0x500 (same index, different tag).
  - Lookup 0x100 -> miss, pred_taken=0, pred_target=0x104.
- Same-cycle update and lookup of the same entry -> outputs reflect old counter in that cycle, new counter the next cycle.
- Assert reset mid-stream with upd_valid=1 -> update ignored, all state at reset values, num_branches=0.
